// File: rtl/dsram_responder_pkg.sv
// Shared definitions for the data-side SRAM responder: FSM encodings,
// byte-enable patterns and wait-counter sizing.
// No logic of its own; imported by dsram_responder and dsram_bytewr_ram.
package dsram_responder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2
  } state_t;

  // Byte-lane write-enable patterns as driven by the pipeline.
  localparam logic [3:0] WE_RD = 4'b0000;
  localparam logic [3:0] WE_B0 = 4'b0001;
  localparam logic [3:0] WE_B1 = 4'b0010;
  localparam logic [3:0] WE_B2 = 4'b0100;
  localparam logic [3:0] WE_B3 = 4'b1000;
  localparam logic [3:0] WE_H0 = 4'b0011;
  localparam logic [3:0] WE_H1 = 4'b1100;
  localparam logic [3:0] WE_W  = 4'b1111;

  // Wide enough for WAIT_CYCLES up to 15.
  localparam int WAIT_CNT_WD = 4;

  // Single-lane enable pattern for lane 0..3.
  function automatic logic [3:0] lane_we(input int lane);
    case (lane)
      0:       return WE_B0;
      1:       return WE_B1;
      2:       return WE_B2;
      default: return WE_B3;
    endcase
  endfunction

endpackage

// File: rtl/dsram_bytewr_ram.sv
// Word-organised single-port RAM with 4 byte-lane write enables.
// Latency: 1 cycle, read data registered and held until the next read.
// Backpressure: none; an access is performed on every cycle en is high.
module dsram_bytewr_ram
  import dsram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem [0:DEPTH-1];

  // Byte-lane writes; the array itself is never reset so contents survive resetn.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if ((we & lane_we(i)) != WE_RD) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read; holds its value on writes and idle cycles so a stalled consumer keeps valid data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata <= '0;
    end else if (en && (we == WE_RD)) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dsram_responder.sv
// Data-side SRAM responder with wait-state insertion; DSRAM_ALIGN_CHK_EN adds the ale misalignment flag.
// Latency: read data registered, valid 1+WAIT_CYCLES cycles after data_sram_en rises.
// Backpressure: stall_req high for exactly WAIT_CYCLES cycles per request; requester holds it stable.
module dsram_responder
  import dsram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stall_req
`ifdef DSRAM_ALIGN_CHK_EN
  ,
  output logic        ale
`endif
);

  localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
  localparam bit ONE_WAIT = (WAIT_CYCLES == 1);
  // The IDLE cycle that first sees en is itself the first stall cycle, so the
  // counter is loaded with the number of stall cycles still to come.
  localparam logic [WAIT_CNT_WD-1:0] WAIT_LOAD =
    HAS_WAIT ? WAIT_CNT_WD'(WAIT_CYCLES - 1) : '0;
  localparam logic [WAIT_CNT_WD-1:0] CNT_ONE = WAIT_CNT_WD'(1);

  state_t                 state;
  logic [WAIT_CNT_WD-1:0] wait_cnt;
  logic                   req_grant;
  logic                   ram_en;
  logic [DEPTH_LOG2-1:0]  ram_idx;
  logic                   unused_addr_bits;

  // Upper bits alias, low two bits select bytes inside the word (consumer's job).
  assign ram_idx          = data_sram_addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{data_sram_addr[31:DEPTH_LOG2+2], data_sram_addr[1:0]};

  // Access happens at this edge: immediately when there are no waits, otherwise in GRANT.
  // Gated by resetn so nothing reaches the RAM while reset is held.
  assign req_grant = resetn && data_sram_en &&
                     (((state == IDLE) && !HAS_WAIT) || (state == GRANT));

  // Stall covers the first request cycle (combinational from en) plus every WAIT cycle.
  assign stall_req = resetn &&
                     ((state == WAIT) || ((state == IDLE) && data_sram_en && HAS_WAIT));

  // Wait-state FSM; a dropped en in WAIT or GRANT abandons the request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (data_sram_en && HAS_WAIT) begin
            wait_cnt <= WAIT_LOAD;
            state    <= ONE_WAIT ? GRANT : WAIT;
          end
        end
        WAIT: begin
          if (!data_sram_en) begin
            wait_cnt <= '0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - CNT_ONE;
            if (wait_cnt == CNT_ONE) begin
              state <= GRANT;
            end
          end
        end
        GRANT: begin
          wait_cnt <= '0;
          state    <= IDLE;
        end
        default: begin
          wait_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef DSRAM_ALIGN_CHK_EN
  logic misaligned;

  // Word stores need addr[1:0]==0, half stores need addr[0]==0; reads are never flagged.
  assign misaligned = ((data_sram_we == WE_W) && (data_sram_addr[1:0] != 2'b00)) ||
                      (((data_sram_we == WE_H0) || (data_sram_we == WE_H1)) &&
                       data_sram_addr[0]);

  // A misaligned store is dropped; it is always a write, so no read is lost.
  assign ram_en = req_grant && !misaligned;

  // One-cycle flag after a granted misaligned access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ale <= 1'b0;
    end else begin
      ale <= req_grant && misaligned;
    end
  end
`else
  assign ram_en = req_grant;
`endif

  dsram_bytewr_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk    (clk),
    .resetn (resetn),
    .en     (ram_en),
    .we     (data_sram_we),
    .idx    (ram_idx),
    .wdata  (data_sram_wdata),
    .rdata  (data_sram_rdata)
  );

endmodule

// File: tb/tb_dsram_responder.sv
// Directed bench for dsram_responder: one instance without wait states, one with three.
// Inputs change on the falling edge; registered outputs are sampled there too.
// Combinational stall_req is sampled 1 time unit after inputs change.
module tb_dsram_responder;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        en0, en3;
  logic [3:0]  we0, we3;
  logic [31:0] addr0, addr3, wdata0, wdata3, rdata0, rdata3;
  logic        stall0, stall3;
`ifdef DSRAM_ALIGN_CHK_EN
  logic        ale0, ale3;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  dsram_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .resetn(resetn),
    .data_sram_en(en0), .data_sram_we(we0), .data_sram_addr(addr0),
    .data_sram_wdata(wdata0), .data_sram_rdata(rdata0), .stall_req(stall0)
`ifdef DSRAM_ALIGN_CHK_EN
    , .ale(ale0)
`endif
  );

  dsram_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .resetn(resetn),
    .data_sram_en(en3), .data_sram_we(we3), .data_sram_addr(addr3),
    .data_sram_wdata(wdata3), .data_sram_rdata(rdata3), .stall_req(stall3)
`ifdef DSRAM_ALIGN_CHK_EN
    , .ale(ale3)
`endif
  );

  // One zero-wait access: drive at a falling edge, return at the next one (access done).
  task automatic acc0(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    en0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    @(negedge clk);
  endtask

  task automatic idle0();
    en0 = 1'b0; we0 = 4'b0000;
    @(negedge clk);
  endtask

  // One three-wait access held for its full 4 cycles, then released.
  task automatic acc3(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    en3 = 1'b1; we3 = we; addr3 = addr; wdata3 = wdata;
    repeat (4) @(negedge clk);
    en3 = 1'b0; we3 = 4'b0000;
  endtask

  task automatic test_reset();
    en0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    en3 = 0; we3 = 0; addr3 = 0; wdata3 = 0;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #10;
    vec_cnt++; if (rdata0 !== 32'h0) begin err_cnt++; $display("FAIL reset_rdata0: got %h expected %h", rdata0, 32'h0); end
    vec_cnt++; if (stall0 !== 1'b0) begin err_cnt++; $display("FAIL reset_stall0: got %b expected 0", stall0); end
    vec_cnt++; if (rdata3 !== 32'h0) begin err_cnt++; $display("FAIL reset_rdata3: got %h expected %h", rdata3, 32'h0); end
    vec_cnt++; if (stall3 !== 1'b0) begin err_cnt++; $display("FAIL reset_stall3: got %b expected 0", stall3); end
`ifdef DSRAM_ALIGN_CHK_EN
    vec_cnt++; if (ale0 !== 1'b0) begin err_cnt++; $display("FAIL reset_ale0: got %b expected 0", ale0); end
`endif
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_rw();
    acc0(4'b1111, 32'h10, 32'hDEADBEEF);
    vec_cnt++; if (rdata0 !== 32'h0) begin err_cnt++; $display("FAIL write_holds_rdata: got %h expected %h", rdata0, 32'h0); end
    acc0(4'b0000, 32'h10, 32'h0);
    vec_cnt++; if (rdata0 !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL word_read: got %h expected %h", rdata0, 32'hDEADBEEF); end
    vec_cnt++; if (stall0 !== 1'b0) begin err_cnt++; $display("FAIL w0_no_stall: got %b expected 0", stall0); end
    idle0();
    vec_cnt++; if (rdata0 !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL idle_hold: got %h expected %h", rdata0, 32'hDEADBEEF); end
  endtask

  task automatic test_byte_lanes();
    acc0(4'b0010, 32'h10, 32'h0000AA00);
    acc0(4'b0000, 32'h10, 32'h0);
    vec_cnt++; if (rdata0 !== 32'hDEADAAEF) begin err_cnt++; $display("FAIL byte1_write: got %h expected %h", rdata0, 32'hDEADAAEF); end
    acc0(4'b1100, 32'h10, 32'h12340000);
    acc0(4'b0000, 32'h10, 32'h0);
    vec_cnt++; if (rdata0 !== 32'h1234AAEF) begin err_cnt++; $display("FAIL half1_write: got %h expected %h", rdata0, 32'h1234AAEF); end
    acc0(4'b1111, 32'h14, 32'h0BADCAFE);
    acc0(4'b0000, 32'h14, 32'h0);
    vec_cnt++; if (rdata0 !== 32'h0BADCAFE) begin err_cnt++; $display("FAIL word14: got %h expected %h", rdata0, 32'h0BADCAFE); end
    acc0(4'b0000, 32'h13, 32'h0);
    vec_cnt++; if (rdata0 !== 32'h1234AAEF) begin err_cnt++; $display("FAIL low_bits_ignored: got %h expected %h", rdata0, 32'h1234AAEF); end
    acc0(4'b0000, 32'h4014, 32'h0);
    vec_cnt++; if (rdata0 !== 32'h0BADCAFE) begin err_cnt++; $display("FAIL alias_4014: got %h expected %h", rdata0, 32'h0BADCAFE); end
    acc0(4'b0000, 32'hFFFFC010, 32'h0);
    vec_cnt++; if (rdata0 !== 32'h1234AAEF) begin err_cnt++; $display("FAIL alias_top: got %h expected %h", rdata0, 32'h1234AAEF); end
    idle0();
  endtask

  task automatic test_back_to_back();
    acc0(4'b1111, 32'h30, 32'hA1A2A3A4);
    vec_cnt++; if (rdata0 !== 32'h1234AAEF) begin err_cnt++; $display("FAIL b2b_hold: got %h expected %h", rdata0, 32'h1234AAEF); end
    acc0(4'b1111, 32'h30, 32'hB1B2B3B4);
    acc0(4'b0000, 32'h30, 32'h0);
    vec_cnt++; if (rdata0 !== 32'hB1B2B3B4) begin err_cnt++; $display("FAIL b2b_raw: got %h expected %h", rdata0, 32'hB1B2B3B4); end
    acc0(4'b0011, 32'h30, 32'h0000C5C5);
    vec_cnt++; if (rdata0 !== 32'hB1B2B3B4) begin err_cnt++; $display("FAIL b2b_write_hold: got %h expected %h", rdata0, 32'hB1B2B3B4); end
    acc0(4'b0000, 32'h30, 32'h0);
    vec_cnt++; if (rdata0 !== 32'hB1B2C5C5) begin err_cnt++; $display("FAIL b2b_half0: got %h expected %h", rdata0, 32'hB1B2C5C5); end
    acc0(4'b1111, 32'h34, 32'h5A5A5A5A);
    acc0(4'b0000, 32'h34, 32'h0);
    vec_cnt++; if (rdata0 !== 32'h5A5A5A5A) begin err_cnt++; $display("FAIL b2b_read34: got %h expected %h", rdata0, 32'h5A5A5A5A); end
    acc0(4'b0000, 32'h30, 32'h0);
    vec_cnt++; if (rdata0 !== 32'hB1B2C5C5) begin err_cnt++; $display("FAIL b2b_read30: got %h expected %h", rdata0, 32'hB1B2C5C5); end
    vec_cnt++; if (stall0 !== 1'b0) begin err_cnt++; $display("FAIL b2b_stall: got %b expected 0", stall0); end
    idle0();
  endtask

  task automatic test_wait_read();
    logic        exp_s;
    logic [31:0] exp_d;
    int          stall_cycles;
    acc3(4'b1111, 32'h20, 32'h55AA55AA);
    vec_cnt++; if (rdata3 !== 32'h0) begin err_cnt++; $display("FAIL w3_write_hold: got %h expected %h", rdata3, 32'h0); end
    stall_cycles = 0;
    en3 = 1'b1; we3 = 4'b0000; addr3 = 32'h20;
    for (int c = 0; c < 4; c++) begin
      #1;
      exp_s = (c < 3);
      if (stall3 === 1'b1) stall_cycles++;
      vec_cnt++; if (stall3 !== exp_s) begin err_cnt++; $display("FAIL w3_stall_c%0d: got %b expected %b", c, stall3, exp_s); end
      @(negedge clk);
      exp_d = (c == 3) ? 32'h55AA55AA : 32'h0;
      vec_cnt++; if (rdata3 !== exp_d) begin err_cnt++; $display("FAIL w3_rdata_c%0d: got %h expected %h", c, rdata3, exp_d); end
    end
    en3 = 1'b0;
    vec_cnt++; if (stall_cycles != 3) begin err_cnt++; $display("FAIL w3_stall_count: got %0d expected 3", stall_cycles); end
    for (int c = 0; c < 2; c++) begin
      #1;
      vec_cnt++; if (stall3 !== 1'b0) begin err_cnt++; $display("FAIL w3_idle_stall: got %b expected 0", stall3); end
      @(negedge clk);
      vec_cnt++; if (rdata3 !== 32'h55AA55AA) begin err_cnt++; $display("FAIL w3_idle_hold: got %h expected %h", rdata3, 32'h55AA55AA); end
    end
  endtask

  task automatic test_wait_drop();
    acc3(4'b1111, 32'h28, 32'h0F0F0F0F);
    acc3(4'b0000, 32'h28, 32'h0);
    vec_cnt++; if (rdata3 !== 32'h0F0F0F0F) begin err_cnt++; $display("FAIL drop_pre: got %h expected %h", rdata3, 32'h0F0F0F0F); end
    // drop in the second WAIT cycle
    en3 = 1'b1; we3 = 4'b1111; addr3 = 32'h20; wdata3 = 32'h11111111;
    @(negedge clk);
    @(negedge clk);
    en3 = 1'b0; #1;
    vec_cnt++; if (stall3 !== 1'b1) begin err_cnt++; $display("FAIL drop2_stall_hold: got %b expected 1", stall3); end
    @(negedge clk); #1;
    vec_cnt++; if (stall3 !== 1'b0) begin err_cnt++; $display("FAIL drop2_stall_fall: got %b expected 0", stall3); end
    @(negedge clk);
    // drop in the first WAIT cycle
    en3 = 1'b1;
    @(negedge clk);
    en3 = 1'b0; #1;
    vec_cnt++; if (stall3 !== 1'b1) begin err_cnt++; $display("FAIL drop1_stall_hold: got %b expected 1", stall3); end
    @(negedge clk); #1;
    vec_cnt++; if (stall3 !== 1'b0) begin err_cnt++; $display("FAIL drop1_stall_fall: got %b expected 0", stall3); end
    @(negedge clk);
    acc3(4'b0000, 32'h20, 32'h0);
    vec_cnt++; if (rdata3 !== 32'h55AA55AA) begin err_cnt++; $display("FAIL drop_ram_unchanged: got %h expected %h", rdata3, 32'h55AA55AA); end
  endtask

  task automatic test_reset_mid_wait();
    acc0(4'b0000, 32'h10, 32'h0);
    idle0();
    en3 = 1'b1; we3 = 4'b1111; addr3 = 32'h20; wdata3 = 32'h77777777;
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    vec_cnt++; if (stall3 !== 1'b0) begin err_cnt++; $display("FAIL rst_stall3: got %b expected 0", stall3); end
    vec_cnt++; if (rdata3 !== 32'h0) begin err_cnt++; $display("FAIL rst_rdata3: got %h expected %h", rdata3, 32'h0); end
    vec_cnt++; if (rdata0 !== 32'h0) begin err_cnt++; $display("FAIL rst_rdata0: got %h expected %h", rdata0, 32'h0); end
    @(negedge clk);
    @(negedge clk);
    en3 = 1'b0; resetn = 1'b1;
    @(negedge clk);
    acc3(4'b0000, 32'h20, 32'h0);
    vec_cnt++; if (rdata3 !== 32'h55AA55AA) begin err_cnt++; $display("FAIL rst_ram3_kept: got %h expected %h", rdata3, 32'h55AA55AA); end
    acc0(4'b0000, 32'h10, 32'h0);
    vec_cnt++; if (rdata0 !== 32'h1234AAEF) begin err_cnt++; $display("FAIL rst_ram0_kept: got %h expected %h", rdata0, 32'h1234AAEF); end
    idle0();
  endtask

`ifdef DSRAM_ALIGN_CHK_EN
  task automatic test_align();
    acc0(4'b1111, 32'h20, 32'hCAFEF00D);
    vec_cnt++; if (ale0 !== 1'b0) begin err_cnt++; $display("FAIL ale_aligned20: got %b expected 0", ale0); end
    acc0(4'b1111, 32'h22, 32'h12345678);
    vec_cnt++; if (ale0 !== 1'b1) begin err_cnt++; $display("FAIL ale_word22: got %b expected 1", ale0); end
    idle0();
    vec_cnt++; if (ale0 !== 1'b0) begin err_cnt++; $display("FAIL ale_one_cycle: got %b expected 0", ale0); end
    acc0(4'b0000, 32'h20, 32'h0);
    vec_cnt++; if (rdata0 !== 32'hCAFEF00D) begin err_cnt++; $display("FAIL ale_write_suppressed: got %h expected %h", rdata0, 32'hCAFEF00D); end
    acc0(4'b0011, 32'h21, 32'h0000BEEF);
    vec_cnt++; if (ale0 !== 1'b1) begin err_cnt++; $display("FAIL ale_half21: got %b expected 1", ale0); end
    acc0(4'b0000, 32'h22, 32'h0);
    vec_cnt++; if (rdata0 !== 32'hCAFEF00D) begin err_cnt++; $display("FAIL ale_misaligned_read: got %h expected %h", rdata0, 32'hCAFEF00D); end
    vec_cnt++; if (ale0 !== 1'b0) begin err_cnt++; $display("FAIL ale_read_flag: got %b expected 0", ale0); end
    acc0(4'b1111, 32'h24, 32'hA5A5A5A5);
    vec_cnt++; if (ale0 !== 1'b0) begin err_cnt++; $display("FAIL ale_aligned24: got %b expected 0", ale0); end
    acc0(4'b0000, 32'h24, 32'h0);
    vec_cnt++; if (rdata0 !== 32'hA5A5A5A5) begin err_cnt++; $display("FAIL ale_aligned_lands: got %h expected %h", rdata0, 32'hA5A5A5A5); end
    idle0();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_back_to_back();
    test_wait_read();
    test_wait_drop();
    test_reset_mid_wait();
`ifdef DSRAM_ALIGN_CHK_EN
    test_align();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
